// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter for the shared data-memory master bus.
// Sequences bus ownership among NUM_MST masters via req/grant pairs, with
// bounded hold time so a busy owner cannot starve waiting masters.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   mst_req     - per-master level request, held until done
//   mst_grant   - registered one-hot (or zero) grant
//   grant_valid - registered OR of mst_grant
//   grant_id    - registered index of current owner, 0 when idle
//   preempt     - registered 1-cycle pulse when the owner is forcibly released
module data_bus_arbiter #(
  parameter int unsigned NUM_MST  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_MST-1:0] mst_req,
  output logic [NUM_MST-1:0] mst_grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               preempt
);

  localparam int unsigned CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               preempt_q, preempt_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  // Round-robin pick: first requester above last_id, else first at or below it.
  logic               found_hi, found_lo;
  logic [ID_W-1:0]    win_hi, win_lo, winner;
  logic [NUM_MST-1:0] oh_hi, oh_lo, winner_oh;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    oh_hi    = '0;
    oh_lo    = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (mst_req[i]) begin
        if (ID_W'(i) > last_id_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = ID_W'(i);
            oh_hi[i] = 1'b1;
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = ID_W'(i);
          oh_lo[i] = 1'b1;
        end
      end
    end
    winner    = found_hi ? win_hi : win_lo;
    winner_oh = found_hi ? oh_hi : oh_lo;
  end

  // Owner is the single set grant bit; everyone else counts as contention.
  logic owner_req, other_req;
  assign owner_req = |(mst_req & grant_q);
  assign other_req = |(mst_req & ~grant_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    preempt_d  = 1'b0;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (|mst_req) begin
          state_d    = S_OWN;
          grant_d    = winner_oh;
          id_d       = winner;
          last_id_d  = winner;
          hold_cnt_d = '0;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          // Normal release wins over a coincident preemption.
          state_d    = S_IDLE;
          grant_d    = '0;
          id_d       = '0;
          hold_cnt_d = '0;
        end else if (other_req) begin
          if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST))) begin
            state_d    = S_IDLE;
            grant_d    = '0;
            id_d       = '0;
            hold_cnt_d = '0;
            preempt_d  = 1'b1;
          end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase

    valid_d = |grant_d;
  end

  // State and output registers; last_id resets so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      preempt_q  <= 1'b0;
      last_id_q  <= ID_W'(NUM_MST - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      preempt_q  <= preempt_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign mst_grant   = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign preempt     = preempt_q;

endmodule
